crc32_arb: RTL and testbench
============================

Name: crc32_arb

Overview:
- Round-robin arbiter and sequencer that shares one crc32_core among NUM_REQ chunk clients, e.g. the IHDR/IEND chunk writer, the IDAT stream writer and an optional tEXt writer.
- Grants the core to one requester for a whole CRC transaction, from start through done.
- Muxes the granted requester's start/val/dat/lst onto the core and routes the core's done/val back to that requester only.
- Sits between the chunk writers and the single crc32_core instance in the PNG encoder top.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- IDX_WD, 2, width of grant index; must equal ceil(log2(NUM_REQ)).
- DATA_WD, 32, CRC data word width.
- WDT_CYC, 1024, watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- req_i  in  NUM_REQ  per-requester request level.
- start_i  in  NUM_REQ  per-requester start pulse.
- val_i  in  NUM_REQ  per-requester data valid.
- dat_i  in  NUM_REQ*DATA_WD  packed data; requester k at [k*DATA_WD +: DATA_WD].
- lst_i  in  NUM_REQ  per-requester last word flag.
- gnt_o  out  NUM_REQ  one-hot grant.
- gnt_id_o  out  IDX_WD  index of the current or last grant.
- done_o  out  NUM_REQ  core done, routed to the granted requester.
- val_o  out  NUM_REQ  core val, routed to the granted requester.
- dat_o  out  DATA_WD  core CRC result, broadcast to all requesters.
- core_start_o  out  1  to crc32_core start_i.
- core_val_o  out  1  to crc32_core val_i.
- core_dat_o  out  DATA_WD  to crc32_core dat_i.
- core_lst_o  out  1  to crc32_core lst_i.
- core_done_i  in  1  from crc32_core done_o.
- core_val_i  in  1  from crc32_core val_o.
- core_dat_i  in  DATA_WD  from crc32_core dat_o.
- err_o  out  1  watchdog abort pulse.

Behaviour:
- Reset values: gnt_o=0, gnt_id_o=0, round-robin pointer ptr=0, state=IDLE, err_o=0. All core_* outputs, done_o and val_o read 0 while no grant is held.
- State IDLE:
  - If any req_i bit is set, select the first set bit searching upward from ptr and wrapping modulo NUM_REQ.
  - Register gnt_o/gnt_id_o and move to GRANT. gnt_o is visible one cycle after req_i.
- State GRANT (waiting for the client's start):
  - Granted start_i=1 → go to BUSY; core_start_o=start_i combinationally in that same cycle.
  - Granted req_i=0 before start → clear gnt_o, set ptr=gnt_id+1 mod NUM_REQ, go to IDLE.
- State BUSY:
  - core_val_o/core_dat_o/core_lst_o follow the granted requester combinationally.
  - done_o[gnt_id]=core_done_i and val_o[gnt_id]=core_val_i; all other bits are 0.
  - req_i is ignored while BUSY.
  - On core_done_i=1, go to RELEASE.
- State RELEASE:
  - Lasts exactly one cycle. gnt_o=0, ptr=gnt_id+1 mod NUM_REQ, then go to IDLE.
  - Minimum gap between two grants is therefore 2 cycles, so back-to-back chunks from one client cannot starve the others.
- Ungranted inputs: start_i/val_i/lst_i from ungranted requesters never reach the core, and neither do any inputs in IDLE or RELEASE.
- Granted start_i during BUSY: ignored, not forwarded.
- Simultaneous requests: strict round-robin from ptr. Example: ptr=2, req_i=4'b1011 → grant 3.
- Wrap-around: ptr at NUM_REQ-1 advances to 0.
- Reset mid-transaction: all of the above return to reset values in the next cycle. crc32_core shares rst, so no partial CRC survives.
- dat_o=core_dat_i at all times. Requesters qualify it with their own val_o/done_o.

Optional Feature:
- Macro: CRC32_ARB_WDT_EN.
- Defined:
  - A counter clears on entry to GRANT or BUSY and on any core_val_i; otherwise it increments in GRANT/BUSY.
  - When it reaches WDT_CYC-1: err_o pulses for 1 cycle, the arbiter forces the RELEASE path (ptr advances) and pulses core_start_o for 1 cycle to reinitialise the core.
- Not defined: no counter; err_o tied 0; a hung client holds the grant indefinitely.

Test Plan:
- Single requester: req_i=4'b0001; start; send "IEND" 32'h49454E44 with lst; lst held for the next beat → gnt_o=0001 one cycle after req; done_o[0]=1 with dat_o=32'hAE426082; gnt_o=0 in RELEASE; ptr=1.
- Contention: req_i=4'b1111 continuously, each client runs a 1-word transaction → grant order 0,1,2,3,0; gnt_o low for ≥1 cycle between grants.
- Ungranted start: requester 2 pulses start_i and val_i while requester 0 is BUSY → core_start_o and core_val_o stay unaffected; requester 0's CRC is unchanged.
- Request withdrawal: req_i[1] rises then falls in GRANT without a start → gnt_o=0 the next cycle; ptr=2; core_start_o never asserted.
- Reset mid-BUSY: assert rst for 1 cycle during requester 3's data → gnt_o=0, gnt_id_o=0, done_o=0 next cycle; the next grant goes to the lowest request from index 0.
- With CRC32_ARB_WDT_EN and WDT_CYC=16: grant requester 0, start, never send val → err_o pulses at cycle 16 after the last activity; gnt_o=0; a pending req_i[1] is granted next.

Source files
------------

// File: rtl/crc32_arb.sv
`default_nettype none
// ============================================================================
// Module   : crc32_arb
// Purpose  : Round-robin arbiter/sequencer that shares a single crc32_core
//            among NUM_REQ chunk writers. One requester owns the core from
//            its start pulse until the core reports done.
// Ports    : clk, rst              - clock, synchronous active-high reset
//            req_i/start_i/val_i/lst_i/dat_i - per-requester request side
//            gnt_o/gnt_id_o        - one-hot grant and grant index
//            done_o/val_o/dat_o    - core results routed back to requesters
//            core_*_o / core_*_i   - connection to the shared crc32_core
//            err_o                 - watchdog abort pulse
// Options  : CRC32_ARB_WDT_EN - enables the hung-client watchdog (WDT_CYC).
// Revision : 1.0 - initial release
// ============================================================================
module crc32_arb #(
  parameter int NUM_REQ = 4,
  parameter int IDX_WD  = 2,
  parameter int DATA_WD = 32,
  parameter int WDT_CYC = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [NUM_REQ-1:0]         start_i,
  input  logic [NUM_REQ-1:0]         val_i,
  input  logic [NUM_REQ*DATA_WD-1:0] dat_i,
  input  logic [NUM_REQ-1:0]         lst_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [IDX_WD-1:0]          gnt_id_o,
  output logic [NUM_REQ-1:0]         done_o,
  output logic [NUM_REQ-1:0]         val_o,
  output logic [DATA_WD-1:0]         dat_o,
  output logic                       core_start_o,
  output logic                       core_val_o,
  output logic [DATA_WD-1:0]         core_dat_o,
  output logic                       core_lst_o,
  input  logic                       core_done_i,
  input  logic                       core_val_i,
  input  logic [DATA_WD-1:0]         core_dat_i,
  output logic                       err_o
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_GRANT   = 2'd1;
  localparam logic [1:0] S_BUSY    = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  if (NUM_REQ < 2 || NUM_REQ > 8 || IDX_WD != $clog2(NUM_REQ) || WDT_CYC < 2)
  begin : g_param_check
    $error("crc32_arb: illegal parameterisation");
  end

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [NUM_REQ-1:0] r_gnt;
  logic [IDX_WD-1:0]  r_gnt_id;
  logic [IDX_WD-1:0]  r_ptr;
  logic [IDX_WD-1:0]  w_sel;
  logic [IDX_WD-1:0]  w_ptr_nxt;
  logic               w_any;
  logic               w_gstart;
  logic               w_withdraw;
  logic               w_release;
  logic               w_wdt_hit;

  // First set request at or above ptr, wrapping. Iterating downward lets the
  // closest-to-ptr match overwrite any farther one.
  always_comb begin
    int j;
    j     = 0;
    w_any = |req_i;
    w_sel = r_ptr;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = int'(r_ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (req_i[IDX_WD'(j)]) w_sel = IDX_WD'(j);
    end
  end

  assign w_gstart   = start_i[r_gnt_id];
  assign w_withdraw = !req_i[r_gnt_id] && !start_i[r_gnt_id];
  assign w_ptr_nxt  = (r_gnt_id == IDX_WD'(NUM_REQ - 1)) ? '0 : r_gnt_id + 1'b1;

  // Any exit from a held grant advances the pointer and drops the grant.
  assign w_release  = (r_state == S_GRANT && w_withdraw && !w_gstart) ||
                      (r_state == S_BUSY && core_done_i) ||
                      w_wdt_hit;

  // State register, grant and pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_gnt    <= '0;
      r_gnt_id <= '0;
      r_ptr    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && w_any) begin
        r_gnt    <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_sel;
        r_gnt_id <= w_sel;
      end else if (w_release) begin
        r_gnt <= '0;
        r_ptr <= w_ptr_nxt;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_any) w_state_nxt = S_GRANT;
      S_GRANT: begin
        if (w_gstart)        w_state_nxt = S_BUSY;
        else if (w_withdraw) w_state_nxt = S_IDLE;
      end
      S_BUSY:    if (core_done_i) w_state_nxt = S_RELEASE;
      S_RELEASE: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
    if (w_wdt_hit) w_state_nxt = S_RELEASE;
  end

  // Output logic: the core only sees the granted requester, and only in the
  // phase where that signal is meaningful.
  always_comb begin
    core_start_o = w_wdt_hit;
    core_val_o   = 1'b0;
    core_dat_o   = '0;
    core_lst_o   = 1'b0;
    done_o       = '0;
    val_o        = '0;
    if (r_state == S_GRANT && w_gstart) core_start_o = 1'b1;
    if (r_state == S_BUSY) begin
      core_val_o       = val_i[r_gnt_id];
      core_dat_o       = dat_i[r_gnt_id*DATA_WD +: DATA_WD];
      core_lst_o       = lst_i[r_gnt_id];
      done_o[r_gnt_id] = core_done_i;
      val_o[r_gnt_id]  = core_val_i;
    end
  end

  assign gnt_o    = r_gnt;
  assign gnt_id_o = r_gnt_id;
  assign dat_o    = core_dat_i;

`ifdef CRC32_ARB_WDT_EN
  localparam int WDT_WD = $clog2(WDT_CYC);

  logic [WDT_WD-1:0] r_wdt_cnt;
  logic              w_held;

  assign w_held    = (r_state == S_GRANT) || (r_state == S_BUSY);
  assign w_wdt_hit = w_held && (r_wdt_cnt == WDT_WD'(WDT_CYC - 1));

  // Cleared on entering GRANT/BUSY and by any core result beat, so it
  // measures idle time of the current owner.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wdt_cnt <= '0;
    end else if (core_val_i ||
                 (w_state_nxt != r_state &&
                  (w_state_nxt == S_GRANT || w_state_nxt == S_BUSY))) begin
      r_wdt_cnt <= '0;
    end else if (w_held) begin
      r_wdt_cnt <= r_wdt_cnt + 1'b1;
    end
  end

  assign err_o = w_wdt_hit;
`else
  assign w_wdt_hit = 1'b0;
  assign err_o     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_crc32_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_crc32_arb
// Purpose  : Directed self-checking bench for crc32_arb. The crc32_core is
//            represented by the bench driving core_done_i/core_val_i/
//            core_dat_i with known CRC results (CRC-32 of "IEND" is
//            32'hAE426082).
// Revision : 1.0 - initial release
// ============================================================================
module tb_crc32_arb;

  localparam int N  = 4;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_i, start_i, val_i, lst_i;
  logic [N*DW-1:0] dat_i;
  logic [N-1:0]    gnt_o, done_o, val_o;
  logic [1:0]      gnt_id_o;
  logic [DW-1:0]   dat_o, core_dat_o, core_dat_i;
  logic            core_start_o, core_val_o, core_lst_o;
  logic            core_done_i, core_val_i, err_o;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  crc32_arb #(.NUM_REQ(N), .IDX_WD(2), .DATA_WD(DW), .WDT_CYC(16)) dut (
    .clk(clk), .rst(rst),
    .req_i(req_i), .start_i(start_i), .val_i(val_i), .dat_i(dat_i), .lst_i(lst_i),
    .gnt_o(gnt_o), .gnt_id_o(gnt_id_o), .done_o(done_o), .val_o(val_o), .dat_o(dat_o),
    .core_start_o(core_start_o), .core_val_o(core_val_o), .core_dat_o(core_dat_o),
    .core_lst_o(core_lst_o), .core_done_i(core_done_i), .core_val_i(core_val_i),
    .core_dat_i(core_dat_i), .err_o(err_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction for requester id: wait for its grant, start,
  // optional intruder beat from another requester, one data word with lst,
  // then the modelled core answers with crc. Ends in the RELEASE cycle.
  task automatic txn(input int id, input logic [31:0] word,
                     input logic [31:0] crc, input int intr);
    int         n;
    logic [3:0] oh;
    n  = 0;
    oh = 4'b0001 << id;
    while (gnt_o == '0 && n < 8) begin
      tick();
      n++;
    end
    check("grant_wait", n >= 1 && n < 8, 1);
    check("grant_id", gnt_id_o, id);
    check("grant_onehot", gnt_o, oh);
    start_i[id] = 1'b1;
    dat_i[id*DW +: DW] = word;
    #1 check("core_start", core_start_o, 1);
    tick();
    start_i[id] = 1'b0;
    if (intr >= 0) begin
      start_i[intr] = 1'b1;
      val_i[intr]   = 1'b1;
      lst_i[intr]   = 1'b1;
      dat_i[intr*DW +: DW] = 32'hDEADBEEF;
      #1;
      check("intr_start", core_start_o, 0);
      check("intr_val", core_val_o, 0);
      check("intr_lst", core_lst_o, 0);
      check("intr_dat", core_dat_o, word);
      tick();
      start_i[intr] = 1'b0;
      val_i[intr]   = 1'b0;
      lst_i[intr]   = 1'b0;
    end
    val_i[id] = 1'b1;
    lst_i[id] = 1'b1;
    #1;
    check("core_val", core_val_o, 1);
    check("core_dat", core_dat_o, word);
    check("core_lst", core_lst_o, 1);
    check("busy_start_blocked", core_start_o, 0);
    tick();
    val_i[id]   = 1'b0;
    core_done_i = 1'b1;
    core_val_i  = 1'b1;
    core_dat_i  = crc;
    #1;
    check("done_route", done_o, oh);
    check("val_route", val_o, oh);
    check("dat_bcast", dat_o, crc);
    tick();
    core_done_i = 1'b0;
    core_val_i  = 1'b0;
    lst_i[id]   = 1'b0;
    #1 check("release_gnt", gnt_o, 0);
    check("release_done", done_o, 0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    req_i = '0; start_i = '0; val_i = '0; lst_i = '0; dat_i = '0;
    core_done_i = 1'b0; core_val_i = 1'b0; core_dat_i = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_gnt", gnt_o, 0);
    check("rst_gnt_id", gnt_id_o, 0);
    check("rst_err", err_o, 0);
    check("rst_core_start", core_start_o, 0);
    check("rst_done", done_o, 0);

    // Single requester "IEND", with requester 2 intruding while 0 is busy.
    req_i = 4'b0001;
    #1 check("gnt_not_early", gnt_o, 0);
    txn(0, 32'h49454E44, 32'hAE426082, 2);
    req_i = '0;

    // Contention: ptr is now 1, so the order is 1,2,3,0,1.
    req_i = 4'b1111;
    txn(1, 32'h11111111, 32'hA1A1A1A1, -1);
    txn(2, 32'h22222222, 32'hB2B2B2B2, -1);
    txn(3, 32'h33333333, 32'hC3C3C3C3, -1);
    txn(0, 32'h44444444, 32'hD4D4D4D4, -1);
    txn(1, 32'h55555555, 32'hE5E5E5E5, -1);

    // Withdrawal of requester 1 in GRANT; ptr must become 2.
    req_i = 4'b0010;
    tick();
    tick();
    check("wd_gnt", gnt_o, 4'b0010);
    req_i = '0;
    #1 check("wd_no_start", core_start_o, 0);
    tick();
    check("wd_gnt_clear", gnt_o, 0);
    req_i = 4'b1011;
    tick();
    check("rr_ptr2_gnt", gnt_id_o, 3);

    // Reset while requester 3 is sending data.
    start_i[3] = 1'b1;
    tick();
    start_i[3] = 1'b0;
    val_i[3] = 1'b1;
    dat_i[3*DW +: DW] = 32'h0BADF00D;
    #1 check("r3_core_val", core_val_o, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_i = 4'b1010;
    #1;
    check("mid_rst_gnt", gnt_o, 0);
    check("mid_rst_gnt_id", gnt_id_o, 0);
    check("mid_rst_done", done_o, 0);
    check("mid_rst_core_val", core_val_o, 0);
    val_i[3] = 1'b0;
    tick();
    check("post_rst_gnt_id", gnt_id_o, 1);
    req_i = '0;
    tick();

    // Hung client: requester 0 starts and never sends data.
    req_i = 4'b0001;
    tick();
    start_i[0] = 1'b1;
    tick();
    start_i[0] = 1'b0;
    req_i = 4'b0011;
    n = 0;
    while (err_o !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
`ifdef CRC32_ARB_WDT_EN
    check("wdt_cycles", n, 15);
    check("wdt_err", err_o, 1);
    check("wdt_core_start", core_start_o, 1);
    tick();
    check("wdt_gnt_clear", gnt_o, 0);
    check("wdt_err_pulse", err_o, 0);
    tick();
    tick();
    check("wdt_next_gnt", gnt_id_o, 1);
`else
    check("hang_no_err", err_o, 0);
    check("hang_holds_gnt", gnt_o, 4'b0001);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
